mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single unified memory port between instruction fetch (IF) and load/store (D) when the core runs with one memory. It arbitrates the two requesters, latches the winner's address and write data, and drives the owner select onto the shared 32-bit address and write-data muxes. It also returns read data or write acknowledges to the winning port. Data accesses have priority, with a bounded-starvation guard for fetch.

## Interface
- `MAX_STARVE`, default 4: number of consecutive D wins tolerated while IF is waiting before IF is forced to win (range 1..15).
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request; held until `if_gnt`.
- `if_addr`  in  32  fetch address.
- `d_req`  in  1  data request; held until `d_gnt`.
- `d_addr`  in  32  data address.
- `d_we`  in  1  1 = write, 0 = read.
- `d_wdata`  in  32  write data.
- `if_gnt` / `d_gnt`  out  1  one-cycle grant pulse. The requester may change or drop req/addr in the following cycle.
- `if_rvalid` / `d_rvalid`  out  1  one-cycle completion pulse: read data valid, or write acknowledged.
- `rdata`  out  32  registered read data, shared by both ports.
- `mem_req`  out  1  shared memory request.
- `mem_addr`  out  32  latched address.
- `mem_we`  out  1  latched write enable; always 0 for IF.
- `mem_wdata`  out  32  latched write data.
- `mem_rdata`  in  32  memory read data; valid when `mem_ready` = 1.
- `mem_ready`  in  1  memory completes the current access in this cycle.
- `mem_sel`  out  1  current owner: 0 = IF, 1 = D.
- `busy`  out  1  high in ACCESS and RESP.

## Operation
- FSM has three states: IDLE, ACCESS, RESP.
- **IDLE**
  - If `d_req` or `if_req` is high, pick a winner (rule below).
  - Latch the winner's addr, we and wdata. For IF, we = 0 and wdata = 0.
  - Set `mem_sel` to the winner and go to ACCESS.
  - With no request, stay in IDLE.
- **ACCESS**
  - `mem_req` = 1. The matching gnt pulses in the first ACCESS cycle only.
  - When `mem_ready` = 1: on a read, capture `mem_rdata` into `rdata`; then go to RESP.
  - Otherwise stay in ACCESS with latched values stable.
- **RESP**
  - The owner's rvalid = 1 for exactly one cycle; `mem_req` = 0.
  - Go to IDLE.
- **Pick rule**
  - Only one requester: it wins.
  - Both requesting: D wins unless `starve_cnt` == `MAX_STARVE`, in which case IF wins.
- **Starvation counter** (`starve_cnt`, width $clog2(MAX_STARVE+1))
  - Increments when D wins while `if_req` = 1.
  - Clears when IF wins.
  - Unchanged otherwise; never exceeds `MAX_STARVE`.
- `rdata` updates only on read completion. Writes leave it holding its previous value.
- `mem_sel` holds its last owner while in IDLE.
- Requests arriving during ACCESS or RESP are not sampled until IDLE; the requester keeps req high.

## Timing
- Reset values (asynchronous, effective immediately while `rst_n` = 0):
  - state = IDLE, `starve_cnt` = 0.
  - `mem_sel` = 0, `mem_req` = 0, `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, `rdata` = 0.
  - all gnt/rvalid = 0, `busy` = 0.
- Latency, with a request sampled in IDLE at edge k:
  - gnt and `mem_req` are high in cycle k+1.
  - With `mem_ready` in cycle k+1, rvalid is high in cycle k+2 and IDLE resumes at k+3.
  - Minimum spacing between accesses is 3 cycles; each extra wait cycle on `mem_ready` adds one cycle.
- Simultaneous requests resolve in one cycle. The loser's req stays pending and is never dropped.
- Reset mid-access: the in-flight access is abandoned and `mem_req` drops asynchronously. No rvalid is issued for it, and requesters must reissue.
- `mem_ready` outside ACCESS is ignored.
- All outputs are driven from registers, except `mem_req`, `busy` and `mem_sel`, which decode directly from state and owner registers.

## Structure
- Shared package `riscv_mem_pkg` holds:
  - the `arb_state_t` enum (IDLE, ACCESS, RESP);
  - `PORT_IF` = 1'b0 and `PORT_D` = 1'b1;
  - `XLEN` = 32.
- The address and write-data paths each instantiate the existing `Mux` (in_1 = IF, in_2 = D, sel = winner) ahead of the latch registers.
- One natural sub-module: `arb_pick`, a combinational winner select plus starvation-counter next-state logic.

## Test plan
- **Lone fetch:** `if_req`=1, `if_addr`=0x0000_0040, `mem_ready`=1 at first ACCESS, `mem_rdata`=0x0000_0013 → `if_gnt` at k+1, `mem_addr`=0x40, `mem_sel`=0, `if_rvalid` at k+2, `rdata`=0x13.
- **Simultaneous requests:** `if_req`=1 and `d_req`=1 read at 0x1000 → D wins, `mem_sel`=1, `d_gnt` first; IF granted in the next IDLE.
- **Starvation guard:** `MAX_STARVE`=4, `d_req` held continuously, `if_req` held → four D grants, fifth grant goes to IF, `starve_cnt` returns to 0.
- **Write with wait states:** `d_we`=1, `d_wdata`=0xDEAD_BEEF, `mem_ready` low for 3 cycles → `mem_we`=1 and `mem_wdata` stable throughout, `d_rvalid` one cycle after ready, `rdata` unchanged.
- **Reset mid-access:** assert `rst_n`=0 during ACCESS → `mem_req`, `busy` and `mem_sel` go to 0 without waiting for a clock edge, no rvalid; after release, a fresh `if_req` completes normally.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM states,
// port identifiers and the machine word width.
package riscv_mem_pkg;

  localparam int XLEN = 32;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

endpackage

// File: rtl/Mux.sv
// Generic two-input word multiplexer: sel = 0 passes in_1, sel = 1 passes in_2.
module Mux #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? in_2 : in_1;

endmodule

// File: rtl/arb_pick.sv
// Combinational winner select for the shared memory port, plus the
// next value of the fetch starvation counter for the chosen winner.
module arb_pick
  import riscv_mem_pkg::*;
#(
  parameter  int MAX_STARVE = 4,
  localparam int CW         = $clog2(MAX_STARVE + 1)
) (
  input  logic          if_req,
  input  logic          d_req,
  input  logic [CW-1:0] starve_cnt,
  output logic          any_req,
  output logic          winner,
  output logic [CW-1:0] starve_next
);

  logic if_owed;

  // Fetch is owed the port once data has won MAX_STARVE times in a row over it.
  assign if_owed = if_req && (starve_cnt == CW'(MAX_STARVE));

  always_comb begin
    any_req     = if_req | d_req;
    winner      = PORT_IF;
    starve_next = starve_cnt;
    if (d_req && !if_owed) begin
      winner = PORT_D;
    end
    if (any_req) begin
      if (winner == PORT_IF) begin
        starve_next = '0;
      end else if (if_req && (starve_cnt != CW'(MAX_STARVE))) begin
        starve_next = starve_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and load/store onto one memory port, latches
// the winning request and returns read data or write acknowledges.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int MAX_STARVE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  input  logic            d_req,
  input  logic [XLEN-1:0] d_addr,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_wdata,
  output logic            if_gnt,
  output logic            d_gnt,
  output logic            if_rvalid,
  output logic            d_rvalid,
  output logic [XLEN-1:0] rdata,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ready,
  output logic            mem_sel,
  output logic            busy
);

  localparam int CW = $clog2(MAX_STARVE + 1);

  arb_state_t      state_reg, state_next;
  logic [CW-1:0]   starve_reg;
  logic [CW-1:0]   starve_next;
  logic            sel_reg;
  logic [XLEN-1:0] addr_reg;
  logic            we_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [XLEN-1:0] rdata_reg;
  logic            if_gnt_reg, d_gnt_reg;
  logic            if_rvalid_reg, d_rvalid_reg;

  logic            any_req;
  logic            winner;
  logic [XLEN-1:0] addr_mux;
  logic [XLEN-1:0] wdata_mux;
  logic [XLEN-1:0] if_wdata;
  logic            load;
  logic            complete;

  // Fetch never writes, so its write-data leg is tied to zero.
  assign if_wdata = '0;

  arb_pick #(
    .MAX_STARVE(MAX_STARVE)
  ) u_pick (
    .if_req     (if_req),
    .d_req      (d_req),
    .starve_cnt (starve_reg),
    .any_req    (any_req),
    .winner     (winner),
    .starve_next(starve_next)
  );

  Mux #(.WIDTH(XLEN)) u_addr_mux (
    .in_1(if_addr),
    .in_2(d_addr),
    .sel (winner),
    .out (addr_mux)
  );

  Mux #(.WIDTH(XLEN)) u_wdata_mux (
    .in_1(if_wdata),
    .in_2(d_wdata),
    .sel (winner),
    .out (wdata_mux)
  );

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = ACCESS;
          load       = 1'b1;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_next = RESP;
          complete   = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      starve_reg    <= '0;
      sel_reg       <= PORT_IF;
      addr_reg      <= '0;
      we_reg        <= 1'b0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      if_gnt_reg    <= 1'b0;
      d_gnt_reg     <= 1'b0;
      if_rvalid_reg <= 1'b0;
      d_rvalid_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      if_gnt_reg    <= load && (winner == PORT_IF);
      d_gnt_reg     <= load && (winner == PORT_D);
      if_rvalid_reg <= complete && (sel_reg == PORT_IF);
      d_rvalid_reg  <= complete && (sel_reg == PORT_D);
      if (load) begin
        sel_reg    <= winner;
        addr_reg   <= addr_mux;
        we_reg     <= (winner == PORT_D) && d_we;
        wdata_reg  <= wdata_mux;
        starve_reg <= starve_next;
      end
      // Writes leave the shared read-data register untouched.
      if (complete && !we_reg) begin
        rdata_reg <= mem_rdata;
      end
    end
  end

  assign if_gnt    = if_gnt_reg;
  assign d_gnt     = d_gnt_reg;
  assign if_rvalid = if_rvalid_reg;
  assign d_rvalid  = d_rvalid_reg;
  assign rdata     = rdata_reg;
  assign mem_addr  = addr_reg;
  assign mem_we    = we_reg;
  assign mem_wdata = wdata_reg;
  assign mem_sel   = sel_reg;
  assign mem_req   = (state_reg == ACCESS);
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter, checked against a
// transaction-level model of arbitration, latching and response timing.
module tb_mem_port_arbiter;

  localparam int MAX_STARVE = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we, mem_ready;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_gnt, d_gnt, if_rvalid, d_rvalid;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic        mem_req, mem_we, mem_sel, busy;

  int          checks = 0;
  int          errors = 0;
  int          starve = 0;
  logic [31:0] exp_rdata = '0;
  logic        exp_sel = 1'b0;

  mem_port_arbiter #(.MAX_STARVE(MAX_STARVE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .d_req    (d_req),
    .d_addr   (d_addr),
    .d_we     (d_we),
    .d_wdata  (d_wdata),
    .if_gnt   (if_gnt),
    .d_gnt    (d_gnt),
    .if_rvalid(if_rvalid),
    .d_rvalid (d_rvalid),
    .rdata    (rdata),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_sel  (mem_sel),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("idle_req", {31'b0, mem_req}, 32'd0);
    chk("idle_gnt", {30'b0, if_gnt, d_gnt}, 32'd0);
    chk("idle_sel", {31'b0, mem_sel}, {31'b0, exp_sel});
  endtask

  // One full transaction, entered at a negedge in IDLE with requests driven.
  task automatic access(input int waits, input logic [31:0] rd, input bit again, output bit win_d);
    logic [31:0] ea, ew;
    logic        ewe;
    bit          if_owed;
    if_owed = if_req && (starve >= MAX_STARVE);
    win_d   = d_req && !if_owed;
    if (!win_d) starve = 0;
    else if (if_req) starve = starve + 1;
    ea  = win_d ? d_addr : if_addr;
    ewe = win_d && d_we;
    ew  = win_d ? d_wdata : 32'd0;
    @(negedge clk);
    chk("gnt_if", {31'b0, if_gnt}, {31'b0, !win_d});
    chk("gnt_d", {31'b0, d_gnt}, {31'b0, win_d});
    chk("req_access", {31'b0, mem_req}, 32'd1);
    chk("sel_access", {31'b0, mem_sel}, {31'b0, win_d});
    chk("addr", mem_addr, ea);
    chk("we", {31'b0, mem_we}, {31'b0, ewe});
    chk("wdata", mem_wdata, ew);
    chk("busy_access", {31'b0, busy}, 32'd1);
    if (win_d) begin
      d_req = again; d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
    end else begin
      if_req = again; if_addr = 32'($urandom) & 32'hFFFF_FFFC;
    end
    mem_ready = (waits == 0);
    mem_rdata = (waits == 0) ? rd : 32'($urandom);
    for (int w = 0; w < waits; w++) begin
      @(negedge clk);
      chk("hold_req", {31'b0, mem_req}, 32'd1);
      chk("hold_addr", mem_addr, ea);
      chk("hold_we", {31'b0, mem_we}, {31'b0, ewe});
      chk("hold_wdata", mem_wdata, ew);
      chk("gnt_once", {30'b0, if_gnt, d_gnt}, 32'd0);
      chk("early_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
      if (w == waits - 1) begin
        mem_ready = 1'b1; mem_rdata = rd;
      end
    end
    @(negedge clk);
    if (!ewe) exp_rdata = rd;
    exp_sel = win_d;
    chk("rvalid_if", {31'b0, if_rvalid}, {31'b0, !win_d});
    chk("rvalid_d", {31'b0, d_rvalid}, {31'b0, win_d});
    chk("req_resp", {31'b0, mem_req}, 32'd0);
    chk("busy_resp", {31'b0, busy}, 32'd1);
    chk("rdata", rdata, exp_rdata);
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(negedge clk);
    chk("rvalid_clear", {30'b0, if_rvalid, d_rvalid}, 32'd0);
    chk("busy_idle", {31'b0, busy}, 32'd0);
    chk("sel_hold", {31'b0, mem_sel}, {31'b0, exp_sel});
    chk("rdata_hold", rdata, exp_rdata);
    mem_ready = 1'b0;
    $display("txn: winner=%s addr=%h we=%0d waits=%0d rdata=%h", win_d ? "D" : "IF", ea, ewe, waits, exp_rdata);
  endtask

  initial begin
    bit w;
    int nd;
    rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    #1;
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_sel", {31'b0, mem_sel}, 32'd0);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_gnt", {30'b0, if_gnt, d_gnt}, 32'd0);
    chk("rst_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_cycle();

    // Lone fetch
    if_req = 1'b1; if_addr = 32'h0000_0040;
    access(0, 32'h0000_0013, 1'b0, w);
    chk("lone_rdata", rdata, 32'h0000_0013);

    // Simultaneous requests: D first, IF next
    if_req = 1'b1; if_addr = 32'h0000_0080;
    d_req = 1'b1; d_addr = 32'h0000_1000; d_we = 1'b0;
    access(0, 32'hCAFE_0001, 1'b0, w);
    chk("simul_first_d", {31'b0, w}, 32'd1);
    access(1, 32'hCAFE_0002, 1'b0, w);
    chk("simul_then_if", {31'b0, w}, 32'd0);

    // Starvation guard: D held continuously, IF held
    if_req = 1'b1; if_addr = 32'h0000_0100;
    d_req = 1'b1; d_addr = 32'h0000_2000; d_we = 1'b0;
    nd = 0;
    for (int i = 0; i < 5; i++) begin
      access($urandom_range(0, 2), $urandom, 1'b1, w);
      if (i < 4 && w) nd++;
      if (i == 4) chk("starve_fifth_if", {31'b0, w}, 32'd0);
    end
    chk("starve_d_wins", nd, 32'd4);
    access(0, $urandom, 1'b0, w);
    chk("starve_cleared_d", {31'b0, w}, 32'd1);
    while (if_req || d_req) access(0, $urandom, 1'b0, w);

    // Write with wait states
    d_req = 1'b1; d_addr = 32'h0000_3000; d_we = 1'b1; d_wdata = 32'hDEAD_BEEF;
    access(3, 32'h5555_AAAA, 1'b0, w);
    chk("write_rdata_kept", rdata, exp_rdata);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1'b1; if_addr = 32'($urandom) & 32'hFFFF_FFFC;
      end
      if (!d_req && $urandom_range(0, 1) == 1) begin
        d_req = 1'b1; d_addr = $urandom; d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom;
      end
      if (if_req || d_req) access($urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)), w);
      else idle_cycle();
    end
    while (if_req || d_req) access(0, $urandom, 1'b0, w);

    // Reset mid-access
    d_req = 1'b1; d_addr = 32'h0000_4000; d_we = 1'b0;
    @(negedge clk);
    chk("mid_gnt", {31'b0, d_gnt}, 32'd1);
    chk("mid_sel", {31'b0, mem_sel}, 32'd1);
    d_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_sel", {31'b0, mem_sel}, 32'd0);
    starve = 0; exp_rdata = '0; exp_sel = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst_no_rvalid", {30'b0, if_rvalid, d_rvalid}, 32'd0);
      chk("arst_idle", {31'b0, busy}, 32'd0);
      mem_ready = 1'b0;
    end
    if_req = 1'b1; if_addr = 32'h0000_0200;
    access(1, 32'h1234_5678, 1'b0, w);
    chk("post_rst_if", {31'b0, w}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
